// File: rtl/captura_instruccion_pkg.sv
// -----------------------------------------------------------------------------
// paquete_monociclo
// Shared definitions for the single-cycle processor fetch path:
//   ANCHO_DIR   - instruction address width
//   ANCHO_INST  - instruction word width
//   PROFUNDIDAD - default depth of the fetched-instruction buffer
//   estado_t    - state encoding of the fetch controller
// -----------------------------------------------------------------------------
package paquete_monociclo;

    localparam int ANCHO_DIR   = 32;
    localparam int ANCHO_INST  = 32;
    localparam int PROFUNDIDAD = 2;

    // LIBRE: no request outstanding; ESPERA: waiting for memory data;
    // DESCARTE: request still outstanding but its data must be dropped.
    typedef enum logic [1:0] {
        LIBRE    = 2'd0,
        ESPERA   = 2'd1,
        DESCARTE = 2'd2
    } estado_t;

endpackage

// File: rtl/captura_instruccion_if.sv
// -----------------------------------------------------------------------------
// captura_instruccion_if
// Instruction-memory read bus.
//   mem_req  - read request (held until mem_ack)
//   mem_dir  - read address (stable while mem_req is high)
//   mem_ack  - memory returns mem_dato this cycle
//   mem_dato - instruction word from memory
// master: fetch stage side; slave: memory side.
// -----------------------------------------------------------------------------
interface captura_instruccion_if #(
    parameter int ANCHO_DIR  = paquete_monociclo::ANCHO_DIR,
    parameter int ANCHO_INST = paquete_monociclo::ANCHO_INST
);

    logic                  mem_req;
    logic [ANCHO_DIR-1:0]  mem_dir;
    logic                  mem_ack;
    logic [ANCHO_INST-1:0] mem_dato;

    modport master (
        output mem_req,
        output mem_dir,
        input  mem_ack,
        input  mem_dato
    );

    modport slave (
        input  mem_req,
        input  mem_dir,
        output mem_ack,
        output mem_dato
    );

endinterface

// File: rtl/captura_instruccion_fifo.sv
// -----------------------------------------------------------------------------
// fifo_instrucciones
// Small FIFO of {address, instruction} pairs between fetch and decode.
//   clk, rst_n            - clock, asynchronous active-low reset
//   push, push_dir/inst   - write an entry at the tail
//   pop                   - remove the head entry (ignored when empty)
//   clear                 - empty the buffer; wins over push/pop in the same cycle
//   full, empty           - occupancy flags
//   head_dir, head_inst   - entry at the read pointer (straight from storage flops)
// -----------------------------------------------------------------------------
module fifo_instrucciones #(
    parameter int ANCHO_DIR   = 32,
    parameter int ANCHO_INST  = 32,
    parameter int PROFUNDIDAD = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [ANCHO_DIR-1:0]  push_dir,
    input  logic [ANCHO_INST-1:0] push_inst,
    input  logic                  pop,
    input  logic                  clear,
    output logic                  full,
    output logic                  empty,
    output logic [ANCHO_DIR-1:0]  head_dir,
    output logic [ANCHO_INST-1:0] head_inst
);

    localparam int PW = (PROFUNDIDAD > 1) ? $clog2(PROFUNDIDAD) : 1;
    localparam int CW = $clog2(PROFUNDIDAD + 1);

    localparam logic [PW-1:0] PTR_MAX      = PW'(PROFUNDIDAD - 1);
    localparam logic [PW-1:0] PTR_CERO     = PW'(0);
    localparam logic [PW-1:0] PTR_UNO      = PW'(1);
    localparam logic [CW-1:0] CUENTA_LLENA = CW'(PROFUNDIDAD);
    localparam logic [CW-1:0] CUENTA_CERO  = CW'(0);
    localparam logic [CW-1:0] CUENTA_UNO   = CW'(1);

    // Pointer increment that also wraps for depths that are not a power of two.
    function automatic logic [PW-1:0] avanza(input logic [PW-1:0] p);
        if (p == PTR_MAX) begin
            return PTR_CERO;
        end else begin
            return p + PTR_UNO;
        end
    endfunction

    logic [ANCHO_DIR-1:0]  dir_q  [PROFUNDIDAD];
    logic [ANCHO_DIR-1:0]  dir_d  [PROFUNDIDAD];
    logic [ANCHO_INST-1:0] inst_q [PROFUNDIDAD];
    logic [ANCHO_INST-1:0] inst_d [PROFUNDIDAD];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cuenta_q, cuenta_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full      = (cuenta_q == CUENTA_LLENA);
    assign empty     = (cuenta_q == CUENTA_CERO);
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign head_dir  = dir_q[rd_ptr_q];
    assign head_inst = inst_q[rd_ptr_q];

    // Next-state for pointers, occupancy and storage; clear overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cuenta_d = cuenta_q;
        dir_d    = dir_q;
        inst_d   = inst_q;
        if (clear) begin
            wr_ptr_d = PTR_CERO;
            rd_ptr_d = PTR_CERO;
            cuenta_d = CUENTA_CERO;
        end else begin
            if (push_ok) begin
                dir_d[wr_ptr_q]  = push_dir;
                inst_d[wr_ptr_q] = push_inst;
                wr_ptr_d         = avanza(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_d = avanza(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   cuenta_d = cuenta_q + CUENTA_UNO;
                2'b01:   cuenta_d = cuenta_q - CUENTA_UNO;
                default: cuenta_d = cuenta_q;
            endcase
        end
    end

    // FIFO state registers; storage resets to zero so the head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= PTR_CERO;
            rd_ptr_q <= PTR_CERO;
            cuenta_q <= CUENTA_CERO;
            for (int i = 0; i < PROFUNDIDAD; i++) begin
                dir_q[i]  <= {ANCHO_DIR{1'b0}};
                inst_q[i] <= {ANCHO_INST{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cuenta_q <= cuenta_d;
            dir_q    <= dir_d;
            inst_q   <= inst_d;
        end
    end

endmodule

// File: rtl/captura_instruccion.sv
// -----------------------------------------------------------------------------
// captura_instruccion
// Instruction fetch stage: accepts addresses from the pc stage, issues one
// instruction-memory read at a time and buffers the returned words for decode.
//   clk, rst_n   - clock, asynchronous active-low reset
//   dirLectura   - fetch address from the pc stage
//   pc_valido    - dirLectura valid
//   pc_listo     - address accepted this cycle (combinational)
//   flush        - taken branch: drop everything in flight
//   mem          - instruction-memory read bus (master side)
//   inst         - head-of-buffer instruction
//   inst_dir     - address of inst
//   inst_valida  - inst/inst_dir valid
//   inst_listo   - decode consumes the head when inst_valida is high
// -----------------------------------------------------------------------------
module captura_instruccion #(
    parameter int ANCHO_DIR   = paquete_monociclo::ANCHO_DIR,
    parameter int ANCHO_INST  = paquete_monociclo::ANCHO_INST,
    parameter int PROFUNDIDAD = paquete_monociclo::PROFUNDIDAD
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ANCHO_DIR-1:0]         dirLectura,
    input  logic                         pc_valido,
    output logic                         pc_listo,
    input  logic                         flush,
    captura_instruccion_if.master        mem,
    output logic [ANCHO_INST-1:0]        inst,
    output logic [ANCHO_DIR-1:0]         inst_dir,
    output logic                         inst_valida,
    input  logic                         inst_listo
);

    import paquete_monociclo::*;

    estado_t              estado_q, estado_d;
    logic [ANCHO_DIR-1:0] mem_dir_q, mem_dir_d;
    logic                 mem_req_q, mem_req_d;
    logic                 fifo_push;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Buffer space is checked here, so the FIFO never sees a push while full.
    assign pc_listo    = (estado_q == LIBRE) & ~fifo_full & ~flush;
    assign mem.mem_req = mem_req_q;
    assign mem.mem_dir = mem_dir_q;
    assign inst_valida = ~fifo_empty;

    // Fetch controller next state, captured address and buffer write strobe.
    always_comb begin
        estado_d  = estado_q;
        mem_dir_d = mem_dir_q;
        fifo_push = 1'b0;
        case (estado_q)
            LIBRE: begin
                // A late ack arriving here (e.g. after reset) is ignored.
                if (pc_valido && pc_listo) begin
                    mem_dir_d = dirLectura;
                    estado_d  = ESPERA;
                end else begin
                    estado_d = LIBRE;
                end
            end
            ESPERA: begin
                if (flush) begin
                    // Request cannot be withdrawn; drain it if not answered yet.
                    estado_d = mem_ack_libre(mem.mem_ack);
                end else if (mem.mem_ack) begin
                    fifo_push = 1'b1;
                    estado_d  = LIBRE;
                end else begin
                    estado_d = ESPERA;
                end
            end
            DESCARTE: begin
                if (mem.mem_ack) begin
                    estado_d = LIBRE;
                end else begin
                    estado_d = DESCARTE;
                end
            end
            default: begin
                estado_d = LIBRE;
            end
        endcase
        // Request flop follows the next state so mem_req is a clean Moore output.
        mem_req_d = (estado_d != LIBRE);
    end

    // On flush in ESPERA: an ack in the same cycle finishes the request.
    function automatic estado_t mem_ack_libre(input logic ack);
        if (ack) begin
            return LIBRE;
        end else begin
            return DESCARTE;
        end
    endfunction

    // Controller registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= LIBRE;
            mem_dir_q <= {ANCHO_DIR{1'b0}};
            mem_req_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            mem_dir_q <= mem_dir_d;
            mem_req_q <= mem_req_d;
        end
    end

    fifo_instrucciones #(
        .ANCHO_DIR   (ANCHO_DIR),
        .ANCHO_INST  (ANCHO_INST),
        .PROFUNDIDAD (PROFUNDIDAD)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_dir  (mem_dir_q),
        .push_inst (mem.mem_dato),
        .pop       (inst_listo),
        .clear     (flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_dir  (inst_dir),
        .head_inst (inst)
    );

endmodule

// File: tb/tb_captura_instruccion.sv
// -----------------------------------------------------------------------------
// tb_captura_instruccion
// Self-checking bench for captura_instruccion. Inputs change 1 time unit after
// the rising edge, outputs are sampled 1 time unit later. Every fetch that must
// reach decode is pushed to exp_q when its memory data is driven, and popped
// and compared when decode consumes the head.
// -----------------------------------------------------------------------------
module tb_captura_instruccion;

    typedef struct packed {
        logic [31:0] dir;
        logic [31:0] inst;
    } entrada_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dirLectura;
    logic        pc_valido;
    logic        pc_listo;
    logic        flush;
    logic [31:0] inst;
    logic [31:0] inst_dir;
    logic        inst_valida;
    logic        inst_listo;

    int compared   = 0;
    int mismatched = 0;
    entrada_t exp_q[$];

    captura_instruccion_if #(.ANCHO_DIR(32), .ANCHO_INST(32)) mem_bus ();

    captura_instruccion #(.ANCHO_DIR(32), .ANCHO_INST(32), .PROFUNDIDAD(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dirLectura  (dirLectura),
        .pc_valido   (pc_valido),
        .pc_listo    (pc_listo),
        .flush       (flush),
        .mem         (mem_bus),
        .inst        (inst),
        .inst_dir    (inst_dir),
        .inst_valida (inst_valida),
        .inst_listo  (inst_listo)
    );

    always #5 clk = ~clk;

    // Memory contents as seen by the bench.
    function automatic logic [31:0] dato_de(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h2002_0005;
        else return (a ^ 32'h8C00_0000) + 32'h0000_1000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        compared++; if (mem_bus.mem_req !== 1'b0) begin mismatched++; $display("FAIL rst_mem_req: got %b want 0", mem_bus.mem_req); end
        compared++; if (mem_bus.mem_dir !== 32'h0) begin mismatched++; $display("FAIL rst_mem_dir: got %h want 0", mem_bus.mem_dir); end
        compared++; if (inst_valida !== 1'b0) begin mismatched++; $display("FAIL rst_inst_valida: got %b want 0", inst_valida); end
        compared++; if ({inst_dir, inst} !== 64'h0) begin mismatched++; $display("FAIL rst_head: got %h/%h want 0/0", inst_dir, inst); end
        compared++; if (pc_listo !== 1'b1) begin mismatched++; $display("FAIL rst_pc_listo: got %b want 1", pc_listo); end
    endtask

    task automatic test_basic();
        entrada_t e;
        tick(); dirLectura = 32'h0; pc_valido = 1'b1; #1;
        compared++; if (pc_listo !== 1'b1) begin mismatched++; $display("FAIL basic_pc_listo: got %b want 1", pc_listo); end
        tick(); // edge N: address accepted
        pc_valido = 1'b0; mem_bus.mem_ack = 1'b1; mem_bus.mem_dato = dato_de(32'h0);
        exp_q.push_back('{dir: 32'h0, inst: dato_de(32'h0)}); #1;
        compared++; if ({mem_bus.mem_req, mem_bus.mem_dir} !== {1'b1, 32'h0}) begin mismatched++; $display("FAIL basic_req: got %b/%h want 1/0", mem_bus.mem_req, mem_bus.mem_dir); end
        compared++; if (inst_valida !== 1'b0) begin mismatched++; $display("FAIL basic_early_valid: got %b want 0", inst_valida); end
        tick(); // edge N+1: data written
        mem_bus.mem_ack = 1'b0; inst_listo = 1'b1; #1;
        compared++; if (inst_valida !== 1'b1) begin mismatched++; $display("FAIL basic_valid_n2: got %b want 1", inst_valida); end
        if (inst_valida === 1'b1) begin
            compared++;
            if (exp_q.size() == 0) begin mismatched++; $display("FAIL basic_pop: unexpected %h/%h", inst_dir, inst); end
            else begin e = exp_q.pop_front(); if ({inst_dir, inst} !== {e.dir, e.inst}) begin mismatched++; $display("FAIL basic_pop: got %h/%h want %h/%h", inst_dir, inst, e.dir, e.inst); end end
        end
        tick(); inst_listo = 1'b0; #1;
        compared++; if ({inst_valida, mem_bus.mem_req} !== 2'b00) begin mismatched++; $display("FAIL basic_idle: got valid=%b req=%b want 0/0", inst_valida, mem_bus.mem_req); end
    endtask

    task automatic test_backpressure();
        entrada_t e;
        int pops;
        tick(); inst_listo = 1'b0; pc_valido = 1'b1; dirLectura = 32'h0;
        tick(); // 0x0 accepted
        dirLectura = 32'h4; mem_bus.mem_ack = 1'b1; mem_bus.mem_dato = dato_de(32'h0);
        exp_q.push_back('{dir: 32'h0, inst: dato_de(32'h0)}); #1;
        compared++; if (pc_listo !== 1'b0) begin mismatched++; $display("FAIL bp_listo_espera: got %b want 0", pc_listo); end
        tick(); mem_bus.mem_ack = 1'b0; #1;
        compared++; if (pc_listo !== 1'b1) begin mismatched++; $display("FAIL bp_listo_one: got %b want 1", pc_listo); end
        tick(); // 0x4 accepted
        dirLectura = 32'h8; mem_bus.mem_ack = 1'b1; mem_bus.mem_dato = dato_de(32'h4);
        exp_q.push_back('{dir: 32'h4, inst: dato_de(32'h4)}); #1;
        compared++; if (mem_bus.mem_dir !== 32'h4) begin mismatched++; $display("FAIL bp_dir4: got %h want 4", mem_bus.mem_dir); end
        tick(); mem_bus.mem_ack = 1'b0; #1;
        compared++; if (pc_listo !== 1'b0) begin mismatched++; $display("FAIL bp_full_listo: got %b want 0", pc_listo); end
        tick(); #1;
        compared++; if ({pc_listo, mem_bus.mem_req, inst_valida} !== 3'b001) begin mismatched++; $display("FAIL bp_held: got listo=%b req=%b valid=%b want 0/0/1", pc_listo, mem_bus.mem_req, inst_valida); end
        inst_listo = 1'b1; #1;
        if (inst_valida === 1'b1) begin
            compared++;
            if (exp_q.size() == 0) begin mismatched++; $display("FAIL bp_pop: unexpected %h/%h", inst_dir, inst); end
            else begin e = exp_q.pop_front(); if ({inst_dir, inst} !== {e.dir, e.inst}) begin mismatched++; $display("FAIL bp_pop: got %h/%h want %h/%h", inst_dir, inst, e.dir, e.inst); end end
        end
        tick(); inst_listo = 1'b0; #1;
        compared++; if (pc_listo !== 1'b1) begin mismatched++; $display("FAIL bp_listo_after_pop: got %b want 1", pc_listo); end
        tick(); // 0x8 accepted
        pc_valido = 1'b0; mem_bus.mem_ack = 1'b1; mem_bus.mem_dato = dato_de(32'h8);
        exp_q.push_back('{dir: 32'h8, inst: dato_de(32'h8)}); #1;
        compared++; if (mem_bus.mem_dir !== 32'h8) begin mismatched++; $display("FAIL bp_dir8: got %h want 8", mem_bus.mem_dir); end
        tick(); mem_bus.mem_ack = 1'b0; inst_listo = 1'b1; pops = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (inst_valida === 1'b1) begin
                pops++; compared++;
                if (exp_q.size() == 0) begin mismatched++; $display("FAIL bp_drain: unexpected %h/%h", inst_dir, inst); end
                else begin e = exp_q.pop_front(); if ({inst_dir, inst} !== {e.dir, e.inst}) begin mismatched++; $display("FAIL bp_drain: got %h/%h want %h/%h", inst_dir, inst, e.dir, e.inst); end end
            end
            tick();
        end
        inst_listo = 1'b0;
        compared++; if (pops != 2) begin mismatched++; $display("FAIL bp_drain_count: got %0d want 2", pops); end
    endtask

    task automatic test_wait();
        entrada_t e;
        int req_cycles;
        int pops;
        tick(); pc_valido = 1'b1; dirLectura = 32'h4;
        tick(); // accepted
        pc_valido = 1'b0; req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                mem_bus.mem_ack = 1'b1; mem_bus.mem_dato = dato_de(32'h4);
                exp_q.push_back('{dir: 32'h4, inst: dato_de(32'h4)});
            end
            #1;
            if (mem_bus.mem_req === 1'b1) req_cycles++;
            compared++; if (mem_bus.mem_dir !== 32'h4) begin mismatched++; $display("FAIL wait_dir: cycle %0d got %h want 4", i, mem_bus.mem_dir); end
            tick();
        end
        mem_bus.mem_ack = 1'b0; #1;
        compared++; if (req_cycles != 4) begin mismatched++; $display("FAIL wait_req_cycles: got %0d want 4", req_cycles); end
        compared++; if (mem_bus.mem_req !== 1'b0) begin mismatched++; $display("FAIL wait_req_drop: got %b want 0", mem_bus.mem_req); end
        inst_listo = 1'b1; pops = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (inst_valida === 1'b1) begin
                pops++; compared++;
                if (exp_q.size() == 0) begin mismatched++; $display("FAIL wait_drain: unexpected %h/%h", inst_dir, inst); end
                else begin e = exp_q.pop_front(); if ({inst_dir, inst} !== {e.dir, e.inst}) begin mismatched++; $display("FAIL wait_drain: got %h/%h want %h/%h", inst_dir, inst, e.dir, e.inst); end end
            end
            tick();
        end
        inst_listo = 1'b0;
        compared++; if (pops != 1) begin mismatched++; $display("FAIL wait_entries: got %0d want 1", pops); end
    endtask

    task automatic test_flush_espera();
        tick(); pc_valido = 1'b1; dirLectura = 32'hC;
        tick(); // accepted, now in ESPERA
        pc_valido = 1'b0; flush = 1'b1; #1;
        compared++; if ({pc_listo, mem_bus.mem_req} !== 2'b01) begin mismatched++; $display("FAIL fe_espera: got listo=%b req=%b want 0/1", pc_listo, mem_bus.mem_req); end
        tick(); flush = 1'b0; #1;
        compared++; if ({pc_listo, mem_bus.mem_req} !== 2'b01) begin mismatched++; $display("FAIL fe_descarte: got listo=%b req=%b want 0/1", pc_listo, mem_bus.mem_req); end
        tick(); mem_bus.mem_ack = 1'b1; mem_bus.mem_dato = 32'hDEAD_BEEF; #1;
        compared++; if ({mem_bus.mem_req, mem_bus.mem_dir} !== {1'b1, 32'hC}) begin mismatched++; $display("FAIL fe_ack_cycle: got %b/%h want 1/c", mem_bus.mem_req, mem_bus.mem_dir); end
        tick(); mem_bus.mem_ack = 1'b0; #1;
        compared++; if ({pc_listo, inst_valida, mem_bus.mem_req} !== 3'b100) begin mismatched++; $display("FAIL fe_after: got listo=%b valid=%b req=%b want 1/0/0", pc_listo, inst_valida, mem_bus.mem_req); end
    endtask

    task automatic test_flush_full();
        entrada_t e;
        int pops;
        tick(); inst_listo = 1'b0; pc_valido = 1'b1; dirLectura = 32'h10;
        tick(); dirLectura = 32'h14; mem_bus.mem_ack = 1'b1; mem_bus.mem_dato = dato_de(32'h10);
        exp_q.push_back('{dir: 32'h10, inst: dato_de(32'h10)});
        tick(); mem_bus.mem_ack = 1'b0;
        tick(); pc_valido = 1'b0; mem_bus.mem_ack = 1'b1; mem_bus.mem_dato = dato_de(32'h14);
        exp_q.push_back('{dir: 32'h14, inst: dato_de(32'h14)});
        tick(); mem_bus.mem_ack = 1'b0; #1;
        compared++; if ({inst_valida, pc_listo} !== 2'b10) begin mismatched++; $display("FAIL ff_full: got valid=%b listo=%b want 1/0", inst_valida, pc_listo); end
        flush = 1'b1; inst_listo = 1'b1;
        tick(); flush = 1'b0; inst_listo = 1'b0; exp_q.delete(); #1;
        compared++; if ({inst_valida, pc_listo} !== 2'b01) begin mismatched++; $display("FAIL ff_cleared: got valid=%b listo=%b want 0/1", inst_valida, pc_listo); end
        pc_valido = 1'b1; dirLectura = 32'h18;
        tick(); pc_valido = 1'b0; mem_bus.mem_ack = 1'b1; mem_bus.mem_dato = dato_de(32'h18);
        exp_q.push_back('{dir: 32'h18, inst: dato_de(32'h18)});
        tick(); mem_bus.mem_ack = 1'b0; inst_listo = 1'b1; pops = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (inst_valida === 1'b1) begin
                pops++; compared++;
                if (exp_q.size() == 0) begin mismatched++; $display("FAIL ff_drain: unexpected %h/%h", inst_dir, inst); end
                else begin e = exp_q.pop_front(); if ({inst_dir, inst} !== {e.dir, e.inst}) begin mismatched++; $display("FAIL ff_drain: got %h/%h want %h/%h", inst_dir, inst, e.dir, e.inst); end end
            end
            tick();
        end
        inst_listo = 1'b0;
        compared++; if (pops != 1) begin mismatched++; $display("FAIL ff_entries: got %0d want 1", pops); end
    endtask

    task automatic test_reset_mid();
        tick(); inst_listo = 1'b0; pc_valido = 1'b1; dirLectura = 32'h1C;
        tick(); dirLectura = 32'h20; mem_bus.mem_ack = 1'b1; mem_bus.mem_dato = dato_de(32'h1C);
        tick(); mem_bus.mem_ack = 1'b0;
        tick(); pc_valido = 1'b0; #1; // 0x20 accepted, request outstanding
        compared++; if ({mem_bus.mem_req, inst_valida} !== 2'b11) begin mismatched++; $display("FAIL rm_before: got req=%b valid=%b want 1/1", mem_bus.mem_req, inst_valida); end
        #2; rst_n = 1'b0; #1;
        compared++; if ({mem_bus.mem_req, inst_valida} !== 2'b00) begin mismatched++; $display("FAIL rm_async: got req=%b valid=%b want 0/0", mem_bus.mem_req, inst_valida); end
        compared++; if ({mem_bus.mem_dir, inst_dir, inst} !== 96'h0) begin mismatched++; $display("FAIL rm_zero: got %h/%h/%h want 0/0/0", mem_bus.mem_dir, inst_dir, inst); end
        tick(); tick(); rst_n = 1'b1;
        mem_bus.mem_ack = 1'b1; mem_bus.mem_dato = 32'hBAD0_0BAD;
        tick(); mem_bus.mem_ack = 1'b0; #1;
        compared++; if ({mem_bus.mem_req, inst_valida, pc_listo} !== 3'b001) begin mismatched++; $display("FAIL rm_late_ack: got req=%b valid=%b listo=%b want 0/0/1", mem_bus.mem_req, inst_valida, pc_listo); end
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; dirLectura = 32'h0; pc_valido = 1'b0; flush = 1'b0; inst_listo = 1'b0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_dato = 32'h0;
        repeat (2) @(posedge clk);
        test_reset();
        tick(); rst_n = 1'b1;
        test_basic();
        test_backpressure();
        test_wait();
        test_flush_espera();
        test_flush_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/captura_instruccion.md
CAPTURA_INSTRUCCION -- requirements
Module: captura_instruccion

Interface
REQ-001 Parameters SHALL be: ANCHO_DIR, 32, address width; ANCHO_INST, 32, instruction width; PROFUNDIDAD, 2, instruction buffer entries.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 dirLectura  in  ANCHO_DIR  fetch address produced by the pc stage.
REQ-005 pc_valido  in  1  dirLectura is valid this cycle.
REQ-006 pc_listo  out  1  address accepted this cycle; pc stage holds dirLectura while low.
REQ-007 flush  in  1  taken branch (SaltoCond & zero); discard everything in flight.
REQ-008 mem_req  out  1  instruction-memory read request.
REQ-009 mem_dir  out  ANCHO_DIR  instruction-memory read address.
REQ-010 mem_ack  in  1  memory returns mem_dato this cycle; latency >= 0 wait cycles.
REQ-011 mem_dato  in  ANCHO_INST  instruction word from memory.
REQ-012 inst  out  ANCHO_INST  head-of-buffer instruction to decode.
REQ-013 inst_dir  out  ANCHO_DIR  address of inst.
REQ-014 inst_valida  out  1  inst/inst_dir valid.
REQ-015 inst_listo  in  1  decode consumes head when inst_valida & inst_listo.

Function
REQ-016 FSM SHALL have states LIBRE, ESPERA, DESCARTE.
REQ-017 pc_listo SHALL be combinational: (estado==LIBRE) & (cuenta<PROFUNDIDAD) & !flush.
REQ-018 LIBRE: on pc_valido & pc_listo, latch dirLectura into mem_dir, go ESPERA.
REQ-019 mem_req SHALL be Moore: 1 in ESPERA and DESCARTE, else 0; mem_dir stable while mem_req=1.
REQ-020 ESPERA: on mem_ack & !flush, write {mem_dir, mem_dato} at tail, go LIBRE.
REQ-021 ESPERA: on flush & !mem_ack go DESCARTE; on flush & mem_ack discard data, go LIBRE.
REQ-022 DESCARTE: keep mem_req until mem_ack, discard data, go LIBRE; flush ignored here.
REQ-023 At most one outstanding memory request at any time.
REQ-024 Latency: address accepted at edge N -> mem_req high cycle N+1 -> with zero-wait ack, inst_valida high cycle N+2.
REQ-025 Buffer: PROFUNDIDAD-entry FIFO, 1-bit wrapping read/write pointers, 2-bit cuenta; inst_valida = (cuenta!=0).
REQ-026 Simultaneous write and pop SHALL leave cuenta unchanged, pointers both advance.
REQ-027 Write is never attempted when full (guaranteed by REQ-017); pop when empty SHALL be ignored.
REQ-028 flush SHALL clear cuenta and pointers at that edge, overriding any same-cycle write or pop; inst_valida low next cycle.
REQ-029 inst/inst_dir SHALL be the entry at the read pointer, no combinational path from mem_dato.

Reset
REQ-030 rst_n low SHALL force immediately: estado=LIBRE, cuenta=0, pointers=0, mem_req=0, mem_dir=0, inst_valida=0.
REQ-031 Buffer storage SHALL reset to 0 so inst=0, inst_dir=0 after reset.
REQ-032 Reset mid-request SHALL drop the request; a late mem_ack after reset release in LIBRE SHALL be ignored.

Structure
REQ-033 ANCHO_DIR, ANCHO_INST and FSM state encoding SHALL live in shared package paquete_monociclo.
REQ-034 Buffer SHALL be sub-module fifo_instrucciones (push, pop, clear, full, empty, head data).

Verification
REQ-035 Reset then dirLectura=0x0000_0000, pc_valido=1, mem_ack same cycle as mem_req, mem_dato=0x2002_0005 -> inst_valida cycle N+2, inst=0x2002_0005, inst_dir=0.
REQ-036 inst_listo=0, three addresses 0x0,0x4,0x8 offered -> two stored, pc_listo=0 with 0x8 held; inst_listo=1 one cycle -> 0x8 accepted next.
REQ-037 mem_ack delayed 3 cycles -> mem_req high 4 cycles, mem_dir=0x4 constant, single entry written.
REQ-038 flush in ESPERA before ack, ack 2 cycles later -> DESCARTE, data dropped, cuenta=0, pc_listo high after ack.
REQ-039 Full buffer, flush with inst_listo=1 same cycle -> cuenta=0, inst_valida=0 next cycle, no spurious pop.
REQ-040 rst_n low mid-ESPERA -> mem_req=0 and inst_valida=0 without clock edge; later mem_ack ignored.
